// File: rtl/fft_sample_loader.sv
// Streams one frame of 2^N_LOG2 samples into the FFT sample RAM write port.
// Define FFT_LOADER_BITREV_EN to store the frame bit-reversed (DIT-ready); otherwise natural order.
module fft_sample_loader #(
    parameter int N_LOG2 = 10,
    parameter int DW     = 16,
    parameter int AW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              ack_i,
    input  logic              s_valid_i,
    input  logic [DW-1:0]     s_data_i,
    output logic              s_ready_o,
    output logic              ram_we_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic [DW-1:0]     ram_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_LOG2-1:0] cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [N_LOG2-1:0] CNT_LAST = '1;

    state_t            state_q, state_d;
    logic [N_LOG2-1:0] cnt_q, cnt_d;
    logic              ram_we_q, ram_we_d;
    logic [AW-1:0]     ram_addr_q, ram_addr_d;
    logic [DW-1:0]     ram_data_q, ram_data_d;
    logic [N_LOG2-1:0] addr_map;
    logic              handshake;

`ifdef FFT_LOADER_BITREV_EN
    genvar gi;
    generate
        for (gi = 0; gi < N_LOG2; gi++) begin : g_bitrev
            assign addr_map[gi] = cnt_q[N_LOG2-1-gi];
        end
    endgenerate
`else
    assign addr_map = cnt_q;
`endif

    assign handshake = s_valid_i && (state_q == ST_LOAD);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;

        // Abort overrides everything, including a same-cycle handshake.
        if (abort_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (start_i) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (handshake) begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = AW'(addr_map);
                        ram_data_d = s_data_i;
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + N_LOG2'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (ack_i) begin
                        state_d = start_i ? ST_LOAD : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign s_ready_o  = (state_q == ST_LOAD);
    assign busy_o     = (state_q == ST_LOAD);
    assign done_o     = (state_q == ST_DONE);
    assign cnt_o      = cnt_q;
    assign ram_we_o   = ram_we_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_data_o = ram_data_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Randomised self-checking bench for fft_sample_loader against a frame-level reference model.
// Build with or without FFT_LOADER_BITREV_EN to match the RTL build.
module tb_fft_sample_loader;

    localparam int N_LOG2 = 10;
    localparam int DW     = 16;
    localparam int AW     = 16;
    localparam int NPTS   = 1 << N_LOG2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i, abort_i, ack_i, s_valid_i;
    logic [DW-1:0]     s_data_i;
    logic              s_ready_o, ram_we_o, busy_o, done_o;
    logic [AW-1:0]     ram_addr_o;
    logic [DW-1:0]     ram_data_o;
    logic [N_LOG2-1:0] cnt_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase of the frame (0 idle, 1 loading, 2 complete) plus the expected write port.
    int m_phase, m_cnt, m_addr, m_data;
    bit m_we;

    fft_sample_loader #(.N_LOG2(N_LOG2), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .ack_i      (ack_i),
        .s_valid_i  (s_valid_i),
        .s_data_i   (s_data_i),
        .s_ready_o  (s_ready_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cnt_o      (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_addr(input int c);
        int r;
        r = 0;
`ifdef FFT_LOADER_BITREV_EN
        for (int i = 0; i < N_LOG2; i++) r = (r << 1) | ((c >> i) & 1);
`else
        r = c;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_we = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".ready"}, 64'(s_ready_o),  64'(m_phase == 1));
        chk({where, ".busy"},  64'(busy_o),     64'(m_phase == 1));
        chk({where, ".done"},  64'(done_o),     64'(m_phase == 2));
        chk({where, ".cnt"},   64'(cnt_o),      64'(m_cnt));
        chk({where, ".we"},    64'(ram_we_o),   64'(m_we));
        chk({where, ".addr"},  64'(ram_addr_o), 64'(m_addr));
        chk({where, ".data"},  64'(ram_data_o), 64'(m_data));
    endtask

    // Applies one cycle of inputs (called at negedge), advances the model, checks at the next negedge.
    task automatic step(input bit st, input bit ab, input bit ak, input bit v, input logic [DW-1:0] d);
        start_i = st; abort_i = ab; ack_i = ak; s_valid_i = v; s_data_i = d;
        m_we = 0;
        if (ab) begin
            m_phase = 0; m_cnt = 0;
        end else if (m_phase == 0) begin
            m_cnt = 0;
            if (st) m_phase = 1;
        end else if (m_phase == 1) begin
            if (v) begin
                m_we = 1; m_addr = ref_addr(m_cnt); m_data = int'(d);
                m_cnt = m_cnt + 1;
                if (m_cnt == NPTS) begin
                    m_cnt = 0; m_phase = 2;
                end
            end
        end else if (ak) begin
            m_phase = st ? 1 : 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs("cyc");
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        start_i = 0; abort_i = 0; ack_i = 0; s_valid_i = 0; s_data_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        $display("reset released, outputs checked");

        // Frame 1: samples 0..N-1 back to back.
        step(1, 0, 0, 0, '0);
        for (int k = 0; k < NPTS; k++) step(0, 0, 0, 1, DW'(k));
        chk("f1.done_phase", 64'(done_o), 64'(1));
        $display("frame 1: %0d contiguous samples loaded", NPTS);

        // Frame 2: random valid gaps, random data, stray start/ack ignored while loading.
        step(0, 0, 1, 1, '0);
        step(1, 0, 0, 0, '0);
        guard = 0;
        while (m_phase == 1 && guard < 5000) begin
            step($urandom_range(0, 1), 0, $urandom_range(0, 1), $urandom_range(0, 1), DW'($urandom));
            guard++;
        end
        chk("f2.timeout", 64'(guard < 5000), 64'(1));
        $display("frame 2: random-gap frame loaded in %0d cycles", guard);

        // In DONE: valid held high but nothing must be accepted; then ack+start goes straight to LOAD.
        for (int k = 0; k < 20; k++) step(0, 0, 0, 1, DW'($urandom));
        step(1, 0, 1, 0, '0);
        chk("b2b.load", 64'(s_ready_o), 64'(1));
        $display("back-to-back restart after 20 held cycles in DONE");

        // Abort on handshake 100: that sample is dropped.
        for (int k = 0; k < 99; k++) step(0, 0, 0, 1, DW'($urandom));
        step(0, 1, 0, 1, 16'hBEEF);
        chk("abort.we", 64'(ram_we_o), 64'(0));
        step(0, 0, 0, 1, DW'($urandom));
        step(1, 0, 0, 0, '0);
        step(0, 0, 0, 1, 16'h1234);
        chk("abort.restart_addr", 64'(ram_addr_o), 64'(ref_addr(0)));
        $display("abort at handshake 100, restart from addr(0)");

        // Async reset in the middle of a frame.
        while (m_cnt < 500) step(0, 0, 0, 1, DW'($urandom));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, DW'($urandom));
        $display("async reset at sample 500, idle without start");

        // Full random-data frame after recovery, then acknowledge to idle.
        step(1, 0, 0, 0, '0);
        guard = 0;
        while (m_phase == 1 && guard < 5000) begin
            step(0, 0, 0, $urandom_range(0, 3) != 0, DW'($urandom));
            guard++;
        end
        chk("f4.timeout", 64'(guard < 5000), 64'(1));
        step(0, 0, 1, 0, '0);
        step(0, 0, 0, 1, '0);
        $display("frame 4 loaded and acknowledged");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
